// File: rtl/onebit_comparator.sv
// Single-bit magnitude comparator stage with cascade inputs.
// Stages chain from MSB to LSB. A stage's cascade inputs come from the
// eq/gre/less outputs of the more-significant stage.
module onebit_comparator #(
  parameter int unsigned CASCADE_EN = 1,
  parameter int unsigned OUT_REG    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic in_valid,
  input  logic casc_eq,
  input  logic casc_gt,
  input  logic casc_lt,
  output logic eq,
  output logic gre,
  output logic less,
  output logic out_valid
);

  logic casc_eq_eff;
  logic casc_gt_eff;
  logic casc_lt_eff;
  logic eq_l;
  logic gt_l;
  logic lt_l;
  logic eq_d;
  logic gt_d;
  logic lt_d;

  // A stage with cascading disabled behaves as the most-significant stage.
  if (CASCADE_EN != 0) begin : g_casc
    assign casc_eq_eff = casc_eq;
    assign casc_gt_eff = casc_gt;
    assign casc_lt_eff = casc_lt;
  end else begin : g_no_casc
    assign casc_eq_eff = 1'b1;
    assign casc_gt_eff = 1'b0;
    assign casc_lt_eff = 1'b0;
  end

  // Local bit compare, then cascade priority gt > lt > eq.
  // An all-low cascade code gives no result.
  always_comb begin
    eq_l = ~(a ^ b);
    gt_l = a & ~b;
    lt_l = ~a & b;
    eq_d = 1'b0;
    gt_d = 1'b0;
    lt_d = 1'b0;
    if (casc_gt_eff) begin
      gt_d = 1'b1;
    end else if (casc_lt_eff) begin
      lt_d = 1'b1;
    end else if (casc_eq_eff) begin
      eq_d = eq_l;
      gt_d = gt_l;
      lt_d = lt_l;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic eq_q;
    logic gt_q;
    logic lt_q;
    logic valid_q;

    // The result is captured only on valid cycles. out_valid marks a fresh result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        eq_q    <= 1'b0;
        gt_q    <= 1'b0;
        lt_q    <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          eq_q <= eq_d;
          gt_q <= gt_d;
          lt_q <= lt_d;
        end
      end
    end

    assign eq        = eq_q;
    assign gre       = gt_q;
    assign less      = lt_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    assign eq        = eq_d;
    assign gre       = gt_d;
    assign less      = lt_d;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_onebit_comparator.sv
// Scoreboard bench for onebit_comparator with default parameters.
// This bench exercises only the registered path with cascading enabled.
module tb_onebit_comparator;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, in_valid, casc_eq, casc_gt, casc_lt;
  logic eq, gre, less, out_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];
  logic [2:0] last_exp = 3'b000;

  onebit_comparator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .casc_eq  (casc_eq),
    .casc_gt  (casc_gt),
    .casc_lt  (casc_lt),
    .eq       (eq),
    .gre      (gre),
    .less     (less),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference model. The cascade code gives a verdict, or defers to an
  // arithmetic comparison of the operand values. Result is {eq, gre, less}.
  function automatic logic [2:0] ref_model(logic av, logic bv, logic ce, logic cg, logic cl);
    int verdict;
    if (cg) verdict = 1;
    else if (cl) verdict = -1;
    else if (ce) verdict = (int'(av) > int'(bv)) ? 1 : ((int'(av) < int'(bv)) ? -1 : 0);
    else verdict = 2;
    if (verdict == 0) return 3'b100;
    if (verdict == 1) return 3'b010;
    if (verdict == -1) return 3'b001;
    return 3'b000;
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic bv, input logic v,
                       input logic ce, input logic cg, input logic cl);
    @(negedge clk);
    a = av; b = bv; in_valid = v; casc_eq = ce; casc_gt = cg; casc_lt = cl;
    if (v) exp_q.push_back(ref_model(av, bv, ce, cg, cl));
  endtask

  // Monitor. A result is checked when out_valid is high. Otherwise the
  // outputs must hold the last result.
  always @(posedge clk) begin
    logic [2:0] e;
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {out_valid, eq, gre, less}, 4'b0000);
      end else begin
        e = exp_q.pop_front();
        check("result", {out_valid, eq, gre, less}, {1'b1, e});
        last_exp = e;
      end
    end else begin
      check("hold", {out_valid, eq, gre, less}, {1'b0, last_exp});
      if (exp_q.size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_result at %0t: got no out_valid expected %b", $time, exp_q[0]);
        exp_q.delete();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with active inputs; the check runs before any clock edge.
    rst_n = 1'b0; a = 1'b1; b = 1'b0; in_valid = 1'b1;
    casc_eq = 1'b1; casc_gt = 1'b0; casc_lt = 1'b0;
    #1;
    check("reset_no_edge", {out_valid, eq, gre, less}, 4'b0000);
    repeat (2) @(negedge clk);
    check("reset_held", {out_valid, eq, gre, less}, 4'b0000);
    rst_n = 1'b1; in_valid = 1'b0;

    // Truth table, back to back
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0, 0);
    drive(1, 0, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 0, 0);

    // Cascade override
    drive(0, 1, 1, 0, 1, 0);
    drive(1, 0, 1, 0, 0, 1);

    // Valid gating: operands change, outputs must hold
    drive(1, 0, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);

    // Mid-stream reset: the in-flight input is discarded and outputs drop immediately
    drive(1, 0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    last_exp = 3'b000;
    #1;
    check("async_reset_drop", {out_valid, eq, gre, less}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    drive(1, 1, 1, 1, 0, 0);
    drive(1, 0, 1, 1, 0, 0);

    // Exhaustive over a, b, casc_eq, casc_gt, casc_lt
    for (int i = 0; i < 32; i++) begin
      drive(i[4], i[3], 1'b1, i[2], i[1], i[0]);
    end

    // Random stimulus with random valid gaps
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    drive(0, 0, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("queue_drained", 4'(exp_q.size()), 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onebit_comparator.md
ONEBIT_COMPARATOR -- requirements
Module: onebit_comparator

Interface
REQ-001 Parameter CASCADE_EN, default 1, meaning: 1 = cascade inputs participate in the result; 0 = cascade inputs ignored (treated as casc_eq=1, casc_gt=0, casc_lt=0).
REQ-002 Parameter OUT_REG, default 1, meaning: 1 = registered outputs, one-cycle latency; 0 = combinational compare outputs and out_valid equal to in_valid.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a  input  1  operand A.
REQ-006 b  input  1  operand B.
REQ-007 in_valid  input  1  a/b/cascade inputs are valid this cycle.
REQ-008 casc_eq  input  1  the more-significant stage reports equality.
REQ-009 casc_gt  input  1  the more-significant stage reports A>B.
REQ-010 casc_lt  input  1  the more-significant stage reports A<B.
REQ-011 eq  output  1  A equals B (including cascade).
REQ-012 gre  output  1  A greater than B (including cascade).
REQ-013 less  output  1  A less than B (including cascade).
REQ-014 out_valid  output  1  eq/gre/less hold a fresh result.

Function
REQ-015 Local compare: eq_l = ~(a^b), gt_l = a & ~b, lt_l = ~a & b.
REQ-016 Cascade priority: casc_gt=1 forces gre=1 and eq=less=0; else casc_lt=1 forces less=1 and eq=gre=0; else casc_eq=1 selects the local result.
REQ-017 Illegal cascade (all three low, or more than one high): casc_gt wins over casc_lt, which wins over casc_eq; all low yields eq=gre=less=0.
REQ-018 Legal inputs produce exactly one of eq/gre/less high (one-hot).
REQ-019 OUT_REG=1: when in_valid=1 at a rising edge, the result is registered into eq/gre/less and out_valid=1 in the next cycle (latency 1).
REQ-020 OUT_REG=1: when in_valid=0 at a rising edge, eq/gre/less hold their previous values and out_valid goes to 0.
REQ-021 OUT_REG=1: back-to-back valid inputs produce back-to-back results with no bubbles (throughput 1 per cycle).
REQ-022 OUT_REG=0: eq/gre/less follow the inputs combinationally regardless of in_valid, and out_valid = in_valid.
REQ-023 No X propagation from the registers after reset; the block has no other state.

Reset
REQ-024 rst_n low immediately (asynchronously) forces eq=0, gre=0, less=0, out_valid=0 in OUT_REG=1.
REQ-025 Outputs stay at reset values while rst_n is low, irrespective of clk and inputs.
REQ-026 Deassertion takes effect at the next rising edge; the first result appears one cycle after the first sampled in_valid=1.
REQ-027 Reset asserted mid-stream discards any in-flight result; no result is produced for inputs sampled while rst_n is low.

Verification
REQ-028 Reset: hold rst_n=0 with a=1, b=0, in_valid=1 -> eq=gre=less=0 and out_valid=0, with no clock edge required.
REQ-029 Truth table (casc_eq=1, in_valid=1), applied at 10-time-unit spacing: (a,b)=(0,0)->eq=1; (0,1)->less=1; (1,0)->gre=1; (1,1)->eq=1; each result appears one cycle later with the other two outputs at 0.
REQ-030 Cascade override: a=0, b=1, casc_gt=1 -> gre=1, less=0; a=1, b=0, casc_lt=1 -> less=1, gre=0.
REQ-031 Valid gating: a result is registered, then in_valid=0 with changed a/b -> outputs unchanged and out_valid=0.
REQ-032 Mid-stream reset: pulse rst_n low between two valid cycles -> outputs drop to 0 immediately, and the next result follows the first valid input after release.
REQ-033 Exhaustive check: all 32 combinations of a, b and the three cascade inputs -> outputs match REQ-015 to REQ-017, with one-hot outputs for legal cascade codes.
